// File: rtl/xout_accum_pkg.sv
// Shared types and helpers for the XOUT frame accumulator.
package xout_accum_pkg;

  typedef enum logic {IDLE, ACCUM} state_t;

  function automatic int cnt_width(input int count);
    return $clog2(count + 1);
  endfunction

endpackage

// File: rtl/xout_frame_accum_if.sv
// Sample stream in, frame-sum stream out. The DUT sits on the slave side.
interface xout_frame_accum_if
  import xout_accum_pkg::*;
#(
  parameter int NBITS    = 8,
  parameter int ACC_BITS = 16,
  parameter int COUNT    = 4
);
  localparam int CW = cnt_width(COUNT);

  logic [NBITS-1:0]    in_data;
  logic                in_valid;
  logic                in_ready;
  logic                flush;
  logic [ACC_BITS-1:0] out_data;
  logic [CW-1:0]       out_cnt;
  logic                out_ovf;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, out_data, out_cnt, out_ovf, out_valid
  );

  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, out_data, out_cnt, out_ovf, out_valid
  );
endinterface

// File: rtl/xout_frame_oreg.sv
// One-deep output slot holding a completed frame until the consumer takes it.
module xout_frame_oreg #(
  parameter int ACC_BITS = 16,
  parameter int CW       = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic [ACC_BITS-1:0] data_i,
  input  logic [CW-1:0]       cnt_i,
  input  logic                ovf_i,
  input  logic                out_ready_i,
  output logic                out_valid_o,
  output logic [ACC_BITS-1:0] out_data_o,
  output logic [CW-1:0]       out_cnt_o,
  output logic                out_ovf_o,
  output logic                slot_ok_o
);
  logic                valid_q;
  logic [ACC_BITS-1:0] data_q;
  logic [CW-1:0]       cnt_q;
  logic                ovf_q;

  // A load wins over a same-edge handshake, giving back-to-back frames.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      cnt_q   <= cnt_i;
      ovf_q   <= ovf_i;
    end else if (valid_q && out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign slot_ok_o   = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_cnt_o   = cnt_q;
  assign out_ovf_o   = ovf_q;
endmodule

// File: rtl/xout_frame_accum.sv
// Sums XOUT samples into frames of COUNT and emits one registered sum per frame.
module xout_frame_accum
  import xout_accum_pkg::*;
#(
  parameter int NBITS    = 8,
  parameter int ACC_BITS = 16,
  parameter int COUNT    = 4
) (
  input logic               clk_i,
  input logic               rst_i,
  xout_frame_accum_if.slave bus
);
  localparam int CW = cnt_width(COUNT);
  localparam int SW = ACC_BITS + 1;

  state_t              state_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [ACC_BITS-1:0] acc_q, acc_d;
  logic                ovf_q, ovf_d;
  logic [SW-1:0]       sum;
  logic                slot_ok, last, accept, closing;

  assign last        = (cnt_q == CW'(COUNT - 1));
  assign bus.in_ready = !(last && !slot_ok);
  assign accept      = bus.in_valid && bus.in_ready;

  assign sum   = SW'(acc_q) + SW'(bus.in_data);
  assign acc_d = accept ? sum[ACC_BITS-1:0] : acc_q;
  assign ovf_d = ovf_q || (accept && sum[ACC_BITS]);
  assign cnt_d = cnt_q + CW'(accept);

  // A flush only closes a non-empty frame, and only when the slot can take it.
  assign closing = (accept && last) ||
                   (bus.flush && slot_ok && (state_q == ACCUM || accept));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (closing) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      ovf_q <= ovf_d;
      if (accept) state_q <= ACCUM;
    end
  end

  xout_frame_oreg #(.ACC_BITS(ACC_BITS), .CW(CW)) u_oreg (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (closing),
    .data_i      (acc_d),
    .cnt_i       (cnt_d),
    .ovf_i       (ovf_d),
    .out_ready_i (bus.out_ready),
    .out_valid_o (bus.out_valid),
    .out_data_o  (bus.out_data),
    .out_cnt_o   (bus.out_cnt),
    .out_ovf_o   (bus.out_ovf),
    .slot_ok_o   (slot_ok)
  );
endmodule

// File: tb/tb_xout_frame_accum.sv
// Directed and soak checks of xout_frame_accum at defaults, ACC_BITS=9 and COUNT=1.
module tb_xout_frame_accum;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  xout_frame_accum_if #(.NBITS(8), .ACC_BITS(16), .COUNT(4)) b  ();
  xout_frame_accum_if #(.NBITS(8), .ACC_BITS(9),  .COUNT(4)) b9 ();
  xout_frame_accum_if #(.NBITS(8), .ACC_BITS(16), .COUNT(1)) b1 ();

  xout_frame_accum #(.NBITS(8), .ACC_BITS(16), .COUNT(4)) dut  (.clk_i(clk), .rst_i(rst), .bus(b));
  xout_frame_accum #(.NBITS(8), .ACC_BITS(9),  .COUNT(4)) dut9 (.clk_i(clk), .rst_i(rst), .bus(b9));
  xout_frame_accum #(.NBITS(8), .ACC_BITS(16), .COUNT(1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(b1));

  // soak reference model state
  int m_cnt, m_acc, m_ocnt, m_odata, accepted, emitted;
  bit m_ovf, m_oval, m_oovf;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic put(input int d);
    b.in_valid = 1'b1; b.in_data = 8'(d); cyc();
  endtask

  task automatic put9(input int d);
    b9.in_valid = 1'b1; b9.in_data = 8'(d); cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc(); cyc();
    vecs++; if (b.out_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %0d want 0", b.out_valid); end
    vecs++; if (b.out_data !== 16'd0) begin errs++; $display("FAIL rst_data got %0d want 0", b.out_data); end
    vecs++; if (b.out_cnt !== 3'd0) begin errs++; $display("FAIL rst_cnt got %0d want 0", b.out_cnt); end
    vecs++; if (b.out_ovf !== 1'b0) begin errs++; $display("FAIL rst_ovf got %0d want 0", b.out_ovf); end
    vecs++; if (b.in_ready !== 1'b1) begin errs++; $display("FAIL rst_in_ready got %0d want 1", b.in_ready); end
    vecs++; if (b9.out_valid !== 1'b0) begin errs++; $display("FAIL rst_valid9 got %0d want 0", b9.out_valid); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    b.out_ready = 1'b1;
    put(10); put(20); put(30);
    vecs++; if (b.out_valid !== 1'b0) begin errs++; $display("FAIL basic_early got %0d want 0", b.out_valid); end
    put(40);
    b.in_valid = 1'b0;
    vecs++; if (b.out_valid !== 1'b1) begin errs++; $display("FAIL basic_valid got %0d want 1", b.out_valid); end
    vecs++; if (b.out_data !== 16'd100) begin errs++; $display("FAIL basic_data got %0d want 100", b.out_data); end
    vecs++; if (b.out_cnt !== 3'd4) begin errs++; $display("FAIL basic_cnt got %0d want 4", b.out_cnt); end
    vecs++; if (b.out_ovf !== 1'b0) begin errs++; $display("FAIL basic_ovf got %0d want 0", b.out_ovf); end
    cyc();
    vecs++; if (b.out_valid !== 1'b0) begin errs++; $display("FAIL basic_pulse got %0d want 0", b.out_valid); end
  endtask

  task automatic test_overflow();
    b9.out_ready = 1'b1;
    put9(255); put9(255); put9(255); put9(255);
    b9.in_valid = 1'b0;
    vecs++; if (b9.out_data !== 9'd508) begin errs++; $display("FAIL ovf_data got %0d want 508", b9.out_data); end
    vecs++; if (b9.out_ovf !== 1'b1) begin errs++; $display("FAIL ovf_flag got %0d want 1", b9.out_ovf); end
    put9(1); put9(1); put9(1); put9(1);
    b9.in_valid = 1'b0;
    vecs++; if (b9.out_data !== 9'd4) begin errs++; $display("FAIL ovf2_data got %0d want 4", b9.out_data); end
    vecs++; if (b9.out_ovf !== 1'b0) begin errs++; $display("FAIL ovf2_flag got %0d want 0", b9.out_ovf); end
    cyc();
  endtask

  task automatic test_backpressure();
    b.out_ready = 1'b0;
    put(10); put(20); put(30); put(40);
    put(5); put(5); put(5);
    vecs++; if (b.out_data !== 16'd100) begin errs++; $display("FAIL bp_hold got %0d want 100", b.out_data); end
    b.in_valid = 1'b1; b.in_data = 8'd5; #1;
    vecs++; if (b.in_ready !== 1'b0) begin errs++; $display("FAIL bp_stall got %0d want 0", b.in_ready); end
    @(posedge clk); #1;
    vecs++; if (b.out_valid !== 1'b1) begin errs++; $display("FAIL bp_valid got %0d want 1", b.out_valid); end
    vecs++; if (b.out_data !== 16'd100) begin errs++; $display("FAIL bp_hold2 got %0d want 100", b.out_data); end
    b.out_ready = 1'b1; #1;
    vecs++; if (b.in_ready !== 1'b1) begin errs++; $display("FAIL bp_release got %0d want 1", b.in_ready); end
    @(posedge clk); #1;
    b.in_valid = 1'b0;
    vecs++; if (b.out_valid !== 1'b1) begin errs++; $display("FAIL bp_b2b got %0d want 1", b.out_valid); end
    vecs++; if (b.out_data !== 16'd20) begin errs++; $display("FAIL bp_data2 got %0d want 20", b.out_data); end
    cyc();
    vecs++; if (b.out_valid !== 1'b0) begin errs++; $display("FAIL bp_drain got %0d want 0", b.out_valid); end
  endtask

  task automatic test_flush();
    b.out_ready = 1'b1;
    b.flush = 1'b1; cyc();
    vecs++; if (b.out_valid !== 1'b0) begin errs++; $display("FAIL flush_noop got %0d want 0", b.out_valid); end
    b.flush = 1'b0;
    put(7); put(8);
    b.in_valid = 1'b0; b.flush = 1'b1; cyc();
    b.flush = 1'b0;
    vecs++; if (b.out_data !== 16'd15) begin errs++; $display("FAIL flush_data got %0d want 15", b.out_data); end
    vecs++; if (b.out_cnt !== 3'd2) begin errs++; $display("FAIL flush_cnt got %0d want 2", b.out_cnt); end
    put(7);
    b.flush = 1'b1; put(3);
    b.flush = 1'b0; b.in_valid = 1'b0;
    vecs++; if (b.out_data !== 16'd10) begin errs++; $display("FAIL flush_acc_data got %0d want 10", b.out_data); end
    vecs++; if (b.out_cnt !== 3'd2) begin errs++; $display("FAIL flush_acc_cnt got %0d want 2", b.out_cnt); end
    cyc();
  endtask

  task automatic test_reset_mid();
    b.out_ready = 1'b1;
    put(9); put(9);
    b.in_valid = 1'b0; rst = 1'b1; cyc(); rst = 1'b0;
    put(1); put(2); put(3);
    vecs++; if (b.out_valid !== 1'b0) begin errs++; $display("FAIL rstmid_none got %0d want 0", b.out_valid); end
    put(4);
    b.in_valid = 1'b0;
    vecs++; if (b.out_data !== 16'd10) begin errs++; $display("FAIL rstmid_data got %0d want 10", b.out_data); end
    vecs++; if (b.out_cnt !== 3'd4) begin errs++; $display("FAIL rstmid_cnt got %0d want 4", b.out_cnt); end
    cyc();
    b.out_ready = 1'b0;
    put(1); put(1); put(1); put(1);
    b.in_valid = 1'b0; rst = 1'b1; cyc(); rst = 1'b0;
    vecs++; if (b.out_valid !== 1'b0) begin errs++; $display("FAIL rsthold_valid got %0d want 0", b.out_valid); end
    vecs++; if (b.out_data !== 16'd0) begin errs++; $display("FAIL rsthold_data got %0d want 0", b.out_data); end
    b.out_ready = 1'b1;
  endtask

  task automatic test_count1();
    b1.out_ready = 1'b1;
    b1.in_valid = 1'b1; b1.in_data = 8'd42; cyc();
    vecs++; if (b1.out_data !== 16'd42) begin errs++; $display("FAIL c1_data got %0d want 42", b1.out_data); end
    vecs++; if (b1.out_cnt !== 1'd1) begin errs++; $display("FAIL c1_cnt got %0d want 1", b1.out_cnt); end
    b1.in_data = 8'd0; cyc();
    b1.in_valid = 1'b0;
    vecs++; if (b1.out_valid !== 1'b1) begin errs++; $display("FAIL c1_b2b got %0d want 1", b1.out_valid); end
    vecs++; if (b1.out_data !== 16'd0) begin errs++; $display("FAIL c1_data2 got %0d want 0", b1.out_data); end
    cyc();
  endtask

  task automatic soak_step(input bit v, input int d, input bit r, input bit f);
    bit slot, rdy, acc, closing, novf;
    int nacc, ncnt;
    b.in_valid = v; b.in_data = 8'(d); b.out_ready = r; b.flush = f; #1;
    slot = !m_oval || r;
    rdy  = !(m_cnt == 3 && !slot);
    vecs++; if (b.in_ready !== rdy) begin errs++; $display("FAIL soak_in_ready got %0d want %0d", b.in_ready, rdy); end
    acc  = v && rdy;
    nacc = acc ? m_acc + d : m_acc;
    novf = m_ovf || (nacc > 65535);
    nacc = nacc % 65536;
    ncnt = m_cnt + int'(acc);
    closing = (acc && m_cnt == 3) || (f && slot && (m_cnt > 0 || acc));
    accepted += int'(acc);
    if (m_oval && r) begin emitted += m_ocnt; m_oval = 1'b0; end
    if (closing) begin
      m_oval = 1'b1; m_odata = nacc; m_ocnt = ncnt; m_oovf = novf;
      m_cnt = 0; m_acc = 0; m_ovf = 1'b0;
    end else begin
      m_cnt = ncnt; m_acc = nacc; m_ovf = novf;
    end
    @(posedge clk); #1;
    vecs++; if (b.out_valid !== m_oval) begin errs++; $display("FAIL soak_valid got %0d want %0d", b.out_valid, m_oval); end
    if (m_oval) begin
      vecs++;
      if (b.out_data !== 16'(m_odata) || b.out_cnt !== 3'(m_ocnt) || b.out_ovf !== m_oovf) begin
        errs++;
        $display("FAIL soak_frame got %0d/%0d/%0d want %0d/%0d/%0d",
                 b.out_data, b.out_cnt, b.out_ovf, m_odata, m_ocnt, m_oovf);
      end
    end
  endtask

  task automatic test_soak();
    b.in_valid = 1'b0; b.flush = 1'b0;
    rst = 1'b1; cyc(); rst = 1'b0;
    m_cnt = 0; m_acc = 0; m_ovf = 1'b0; m_oval = 1'b0;
    m_ocnt = 0; m_odata = 0; m_oovf = 1'b0;
    accepted = 0; emitted = 0;
    for (int i = 0; i < 500; i++)
      soak_step($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)),
                $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0);
    for (int i = 0; i < 3; i++) soak_step(1'b0, 0, 1'b1, 1'b1);
    vecs++; if (emitted !== accepted) begin errs++; $display("FAIL soak_conserve got %0d want %0d", emitted, accepted); end
    b.flush = 1'b0;
  endtask

  initial begin
    b.in_valid = 1'b0;  b.in_data = '0;  b.flush = 1'b0;  b.out_ready = 1'b0;
    b9.in_valid = 1'b0; b9.in_data = '0; b9.flush = 1'b0; b9.out_ready = 1'b0;
    b1.in_valid = 1'b0; b1.in_data = '0; b1.flush = 1'b0; b1.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_count1();
    test_soak();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
